// File: rtl/ptcalc_mul_arbiter_if.sv
// Request/response bundle for the shared multiplier arbiter.
// master drives requests and consumes responses; slave is the arbiter.
interface ptcalc_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [30:0]           rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin time-sharing of one external 16x16 multiplier:
// operand register (S1), product register (S2), tagged response.
module ptcalc_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    ptcalc_mul_arbiter_if.slave bus,
    output logic [15:0] mul_din0,
    output logic [15:0] mul_din1,
    input  logic [30:0] mul_dout,
    output logic        busy
);
    logic              r_s1_vld;
    logic              r_s2_vld;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic [ID_W-1:0]   r_s1_id;
    logic [ID_W-1:0]   r_s2_id;
    logic [30:0]       r_p;
    logic [ID_W-1:0]   r_ptr;

    logic                 w_s2_adv;
    logic                 w_s1_take;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_gnt;
    logic [ID_W-1:0]      w_nxt;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_acc;
    logic [15:0]          w_a;
    logic [15:0]          w_b;

    assign w_s2_adv  = !r_s2_vld || bus.rsp_ready;
    assign w_s1_take = !r_s1_vld || w_s2_adv;

    // Rotate so bit k of w_rot is requester (r_ptr + k) mod NUM_REQ.
    assign w_rot = {bus.req_valid, bus.req_valid} >> r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_nxt = ID_W'((int'(w_gnt) + 1) % NUM_REQ);

    always_comb begin
        w_ready = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == ID_W'(i)) begin
                w_ready[i] = w_found && w_s1_take && ap_rst_n;
                w_a        = bus.req_a[i*16 +: 16];
                w_b        = bus.req_b[i*16 +: 16];
            end
        end
    end

    assign w_acc = |w_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_s1_id  <= '0;
            r_s2_id  <= '0;
            r_p      <= '0;
            r_ptr    <= '0;
        end else begin
            if (w_s1_take) begin
                r_s1_vld <= w_acc;
                if (w_acc) begin
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_s1_id <= w_gnt;
                    r_ptr   <= w_nxt;
                end
            end
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
                r_p      <= mul_dout;
                r_s2_id  <= r_s1_id;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_s2_vld;
    assign bus.rsp_id    = r_s2_id;
    assign bus.rsp_p     = r_p;
    assign mul_din0      = r_a;
    assign mul_din1      = r_b;
    assign busy          = r_s1_vld || r_s2_vld;
endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Scoreboard bench for ptcalc_mul_arbiter with an ideal multiplier model.
// Stimulus pushes expected {id, product}; a negedge monitor pops on handshake.
module tb_ptcalc_mul_arbiter;
    typedef struct {
        logic [1:0]  id;
        logic [30:0] p;
    } exp_t;

    localparam logic [30:0] P0 = 31'h0000000F;
    localparam logic [30:0] P1 = 31'h00010000;
    localparam logic [30:0] P2 = 31'h00012340;
    localparam logic [30:0] P3 = 31'h7FFE0001;

    logic        clk;
    logic        rst_n;
    logic [15:0] din0;
    logic [15:0] din1;
    logic [30:0] dout;
    logic        busy;
    logic [31:0] full_prod;

    int   n_chk;
    int   n_err;
    exp_t sb[$];

    ptcalc_mul_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    ptcalc_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus),
        .mul_din0 (din0),
        .mul_din1 (din1),
        .mul_dout (dout),
        .busy     (busy)
    );

    assign full_prod = 32'(din0) * 32'(din1);
    assign dout      = full_prod[30:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(logic [1:0] id, logic [30:0] p);
        exp_t e;
        e.id = id;
        e.p  = p;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, bus.rsp_id}, 32'hFFFFFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", {30'd0, bus.rsp_id}, {30'd0, e.id});
                    chk("rsp_p", {1'b0, bus.rsp_p}, {1'b0, e.p});
                end
            end
        end
    end

    task automatic drain_empty(string name);
        repeat (4) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        bus.req_a     = {16'hFFFF, 16'h1234, 16'h0100, 16'h0003};
        bus.req_b     = {16'hFFFF, 16'h0010, 16'h0100, 16'h0005};
        #2;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_p", {1'b0, bus.rsp_p}, 0);
        chk("rst_rsp_id", {30'd0, bus.rsp_id}, 0);
        chk("rst_din0", {16'd0, din0}, 0);
        chk("rst_din1", {16'd0, din1}, 0);
        chk("rst_req_ready", {28'd0, bus.req_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 2
        @(posedge clk);
        #1 bus.req_valid = 4'b0100;
        push(2'd2, P2);
        #1 chk("single_ready", {28'd0, bus.req_ready}, 32'h4);
        @(posedge clk);
        #1 bus.req_valid = '0;
        chk("single_lat1_valid", {31'd0, bus.rsp_valid}, 0);
        chk("single_lat1_busy", {31'd0, busy}, 1);
        @(posedge clk);
        #1 chk("single_lat2_valid", {31'd0, bus.rsp_valid}, 1);
        chk("single_lat2_id", {30'd0, bus.rsp_id}, 2);
        @(posedge clk);
        #1 chk("single_busy_fall", {31'd0, busy}, 0);
        drain_empty("single_drain");

        // All four valid from reset: grants 0,1,2,3,0,...
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            case (n % 4)
                0: push(2'd0, P0);
                1: push(2'd1, P1);
                2: push(2'd2, P2);
                default: push(2'd3, P3);
            endcase
        end
        for (int n = 0; n < 8; n++) begin
            #1 chk("rr_grant", {28'd0, bus.req_ready}, 32'(1 << (n % 4)));
            if (n >= 2)
                chk("rr_stream_valid", {31'd0, bus.rsp_valid}, 1);
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        drain_empty("rr_drain");

        // Backpressure with three pending requests (pointer is 0)
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0111;
        push(2'd0, P0);
        push(2'd1, P1);
        push(2'd2, P2);
        @(posedge clk);
        #1 bus.req_valid = 4'b0110;
        @(posedge clk);
        #1 bus.req_valid = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            #1 chk("bp_ready_low", {28'd0, bus.req_ready}, 0);
            chk("bp_hold_id", {30'd0, bus.rsp_id}, 0);
            chk("bp_hold_p", {1'b0, bus.rsp_p}, {1'b0, P0});
            chk("bp_busy", {31'd0, busy}, 1);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp_release_grant", {28'd0, bus.req_ready}, 32'h4);
        @(posedge clk);
        #1 bus.req_valid = '0;
        drain_empty("bp_drain");

        // Pointer fairness: req 3 alone, then req 0 and 3 together
        @(posedge clk);
        #1 bus.req_valid = 4'b1000;
        push(2'd3, P3);
        @(posedge clk);
        #1 bus.req_valid = 4'b1001;
        push(2'd0, P0);
        push(2'd3, P3);
        #1 chk("fair_first", {28'd0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1 bus.req_valid = 4'b1000;
        #1 chk("fair_second", {28'd0, bus.req_ready}, 32'h8);
        @(posedge clk);
        #1 bus.req_valid = '0;
        drain_empty("fair_drain");

        // Reset with both stages full; nothing from before may emerge
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        @(posedge clk);
        #1 bus.req_valid = 4'b0010;
        @(posedge clk);
        #1 chk("mid_full_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_ready", {28'd0, bus.req_ready}, 0);
        @(posedge clk);
        #3 bus.req_valid = 4'b0110;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        push(2'd1, P1);
        #1 chk("mid_first_grant", {28'd0, bus.req_ready}, 32'h2);
        @(posedge clk);
        #1 bus.req_valid = '0;
        drain_empty("mid_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
